// File: rtl/spi_flash_writer.sv
// spi_flash_writer: copies whole 256-byte pages from a read-only RAM into an
// SPI NOR flash. Each job sends a wake-up, then for every page an optional
// sector erase (when the page starts a 4 KiB sector), a page program and
// the busy-polling that follows each erase/program.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start             one-cycle job request, accepted only when idle
//   flash_addr        first flash address of the job (bits [7:0] ignored)
//   page_count        number of pages to write (0 completes immediately)
//   ram_address       RAM read address, ram_cs read strobe, ram_dataout data
//                     (data valid the cycle after ram_cs)
//   spi_clk/mosi/cs   SPI mode-0 master pins (spi_cs active-low), spi_miso in
//   busy              high while a job runs
//   write_complete    one-cycle pulse when a job finishes successfully
//   error             sticky status-poll timeout flag, cleared on next start
module spi_flash_writer #(
  parameter int          CLK_DIV    = 3,
  parameter logic [15:0] RAM_BASE   = 16'h8000,
  parameter int          POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [8:0]  page_count,
  output logic [15:0] ram_address,
  input  logic [7:0]  ram_dataout,
  output logic        ram_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs,
  input  logic        spi_miso,
  output logic        busy,
  output logic        write_complete,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, GAP, FETCH, LOAD, SHIFT, NEXT, DONE} state_t;
  typedef enum logic [2:0] {C_WAKE, C_WREN_E, C_ERASE, C_POLL_E,
                            C_WREN_P, C_PROG, C_POLL_P} cmd_t;

  state_t      state, state_next;
  cmd_t        cmd;
  logic [8:0]  byte_idx;     // byte position inside the current command
  logic [2:0]  bit_cnt;
  logic [8:0]  div_cnt;      // spi_clk half-period and chip-select gap timer
  logic [16:0] poll_cnt;     // status bytes already read in this poll
  logic [15:0] page;         // flash_addr[23:8] of the page being written
  logic [8:0]  pages_left;
  logic [6:0]  sh;           // bits of the current byte not yet on mosi
  logic        last_bit;     // most recent miso sample (status bit0 at byte end)
  logic [7:0]  tx;

  logic is_poll, half_tick, gap_tick, byte_end, cmd_end, timeout, data_byte, data_next;
  logic unused_ok;

  assign unused_ok = ^flash_addr[7:0];

  function automatic logic [7:0] opcode(input cmd_t c);
    case (c)
      C_WAKE:             return 8'hAB;
      C_WREN_E, C_WREN_P: return 8'h06;
      C_ERASE:            return 8'h20;
      C_PROG:             return 8'h02;
      default:            return 8'h05;
    endcase
  endfunction

  function automatic cmd_t cmd_after(input cmd_t c, input logic aligned);
    case (c)
      C_WAKE:   return aligned ? C_WREN_E : C_WREN_P;
      C_WREN_E: return C_ERASE;
      C_ERASE:  return C_POLL_E;
      C_POLL_E: return C_WREN_P;
      C_WREN_P: return C_PROG;
      default:  return C_POLL_P;
    endcase
  endfunction

  assign is_poll   = (cmd == C_POLL_E) || (cmd == C_POLL_P);
  assign half_tick = (div_cnt == 9'(CLK_DIV - 1));
  assign gap_tick  = (div_cnt == 9'(2 * CLK_DIV - 1));
  // the byte ends on the falling spi_clk edge that follows its eighth rise
  assign byte_end  = (state == SHIFT) && half_tick && spi_clk && (bit_cnt == 3'd7);
  assign timeout   = is_poll && (byte_idx != 9'd0) && last_bit &&
                     (poll_cnt == 17'(POLL_LIMIT - 1));
  assign data_byte = (cmd == C_PROG) && (byte_idx >= 9'd4);
  assign data_next = (cmd == C_PROG) && (byte_idx >= 9'd3);

  always_comb begin
    cmd_end = 1'b0;
    case (cmd)
      C_ERASE: cmd_end = (byte_idx == 9'd3);
      C_PROG:  cmd_end = (byte_idx == 9'd259);
      C_POLL_E, C_POLL_P: cmd_end = (byte_idx != 9'd0) && !last_bit;
      default: cmd_end = 1'b1;
    endcase
  end

  always_comb begin
    tx = 8'h00;
    if (byte_idx == 9'd0)      tx = opcode(cmd);
    else if (is_poll)          tx = 8'h00;
    else if (data_byte)        tx = ram_dataout;
    else if (byte_idx == 9'd1) tx = page[15:8];
    else if (byte_idx == 9'd2) tx = page[7:0];
  end

  assign busy           = (state != IDLE) && (state != DONE);
  assign write_complete = (state == DONE);
  assign ram_cs         = (state == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (page_count == 9'd0) ? DONE : LOAD;
      GAP:   if (gap_tick) state_next = LOAD;
      FETCH: state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (byte_end) begin
               if (timeout)              state_next = IDLE;
               else if (cmd_end)         state_next = (cmd == C_POLL_P) ? NEXT : GAP;
               else                      state_next = data_next ? FETCH : LOAD;
             end
      NEXT:  state_next = (pages_left == 9'd1) ? DONE : GAP;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // control and pin registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cs      <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
      ram_address <= RAM_BASE;
      error       <= 1'b0;
      cmd         <= C_WAKE;
      byte_idx    <= 9'd0;
      bit_cnt     <= 3'd0;
      div_cnt     <= 9'd0;
      poll_cnt    <= 17'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          error       <= 1'b0;
          cmd         <= C_WAKE;
          byte_idx    <= 9'd0;
          poll_cnt    <= 17'd0;
          ram_address <= RAM_BASE;
        end
        GAP: div_cnt <= gap_tick ? 9'd0 : div_cnt + 9'd1;
        LOAD: begin
          spi_cs   <= 1'b0;
          spi_clk  <= 1'b0;
          spi_mosi <= tx[7];
          bit_cnt  <= 3'd0;
          div_cnt  <= 9'd0;
          if (data_byte) ram_address <= ram_address + 16'd1;
        end
        SHIFT: begin
          if (half_tick) begin
            div_cnt <= 9'd0;
            spi_clk <= ~spi_clk;
            if (spi_clk && (bit_cnt != 3'd7)) begin
              bit_cnt  <= bit_cnt + 3'd1;
              spi_mosi <= sh[6];
            end
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
          if (byte_end) begin
            if (is_poll && (byte_idx != 9'd0)) poll_cnt <= poll_cnt + 17'd1;
            if (cmd_end || timeout) begin
              spi_cs   <= 1'b1;
              byte_idx <= 9'd0;
              poll_cnt <= 17'd0;
              if (timeout) error <= 1'b1;
              if (cmd_end && (cmd != C_POLL_P)) cmd <= cmd_after(cmd, page[3:0] == 4'h0);
            end else begin
              // status reads repeat at index 1 so the counter cannot overflow
              byte_idx <= is_poll ? 9'd1 : byte_idx + 9'd1;
            end
          end
        end
        NEXT: begin
          cmd     <= (page[3:0] == 4'hF) ? C_WREN_E : C_WREN_P;
          div_cnt <= 9'd0;
        end
        default: ;
      endcase
    end
  end

  // data registers
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        page       <= flash_addr[23:8];
        pages_left <= page_count;
      end
      LOAD: sh <= tx[6:0];
      SHIFT: if (half_tick) begin
        if (!spi_clk)                last_bit <= spi_miso;
        else if (bit_cnt != 3'd7)    sh <= {sh[5:0], 1'b0};
      end
      NEXT: begin
        page       <= page + 16'd1;
        pages_left <= pages_left - 9'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with a small SPI flash model (frame
// log, programmable WIP behaviour) and a RAM model returning a fixed
// address-derived pattern one cycle after ram_cs.
module tb_spi_flash_writer;
  localparam int CLK_DIV    = 2;
  localparam int POLL_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_addr = 24'h0;
  logic [8:0]  page_count = 9'd0;
  logic [15:0] ram_address;
  logic [7:0]  ram_dataout = 8'h00;
  logic        ram_cs;
  logic        spi_clk, spi_mosi, spi_cs;
  logic        spi_miso = 1'b0;
  logic        busy, write_complete, error;

  int checks = 0;
  int errors = 0;

  spi_flash_writer #(.CLK_DIV(CLK_DIV), .RAM_BASE(16'h8000), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr), .page_count(page_count),
    .ram_address(ram_address), .ram_dataout(ram_dataout), .ram_cs(ram_cs),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .busy(busy), .write_complete(write_complete), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors and models ----------------
  int cyc = 0;
  always @(negedge clk) cyc = cyc + 1;

  logic [7:0] q_bytes[$];
  int         fstart[$];
  int         fid = 0, seen_fid = 0, bitn = 0, fbytes = 0;
  logic [7:0] rx_sh = 8'h00;
  int         up_cyc = 0, min_gap = 1000000;
  int         wip_polls = 3;
  bit         wip_forever = 1'b0;

  always @(negedge spi_cs) begin
    fstart.push_back(q_bytes.size());
    fid = fid + 1;
    if (cyc - up_cyc < min_gap) min_gap = cyc - up_cyc;
  end
  always @(posedge spi_cs) up_cyc = cyc;

  always @(posedge spi_clk) begin
    if (spi_cs === 1'b0) begin
      if (seen_fid != fid) begin
        seen_fid = fid; bitn = 0; fbytes = 0;
      end
      rx_sh = {rx_sh[6:0], spi_mosi};
      bitn  = bitn + 1;
      if (bitn == 8) begin
        q_bytes.push_back(rx_sh);
        bitn = 0;
        fbytes = fbytes + 1;
      end
    end
  end

  // status byte k (k = fbytes-1) reports WIP while k < wip_polls
  always @(negedge spi_clk) spi_miso = wip_forever || ((fbytes - 1) < wip_polls);

  function automatic logic [7:0] ram_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge clk) if (ram_cs === 1'b1) ram_dataout <= ram_f(ram_address);

  logic [15:0] ram_log[$];
  int wc_n = 0, wcbusy = 0;
  always @(negedge clk) begin
    if (ram_cs === 1'b1) ram_log.push_back(ram_address);
    if (write_complete === 1'b1) begin
      wc_n = wc_n + 1;
      if (busy !== 1'b0) wcbusy = wcbusy + 1;
    end
  end

  // ---------------- helpers ----------------
  int f0 = 0, r0 = 0, w0 = 0;

  task automatic mark();
    f0 = fstart.size(); r0 = ram_log.size(); w0 = wc_n;
  endtask

  function automatic int nfr();
    return fstart.size() - f0;
  endfunction

  function automatic int flen(input int f);
    int g = f0 + f;
    if (g >= fstart.size()) return -1;
    if (g + 1 < fstart.size()) return fstart[g+1] - fstart[g];
    return q_bytes.size() - fstart[g];
  endfunction

  function automatic logic [7:0] fb(input int f, input int i);
    if (f0 + f >= fstart.size() || i >= flen(f)) return 8'hEE;
    return q_bytes[fstart[f0+f] + i];
  endfunction

  function automatic logic [31:0] hdr(input int f);
    return {fb(f, 0), fb(f, 1), fb(f, 2), fb(f, 3)};
  endfunction

  function automatic int data_mis(input int f, input logic [15:0] base);
    int m = 0;
    for (int i = 0; i < 256; i++)
      if (fb(f, 4 + i) !== ram_f(base + 16'(i))) m++;
    return m;
  endfunction

  function automatic logic [15:0] first_ram();
    if (r0 >= ram_log.size()) return 16'hDEAD;
    return ram_log[r0];
  endfunction

  task automatic pulse_start(input logic [23:0] a, input logic [8:0] p);
    flash_addr = a; page_count = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (write_complete !== 1'b1 && error !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(n < 30000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_spi_cs", spi_cs, 1);
    chk("rst_spi_clk", spi_clk, 0);
    chk("rst_spi_mosi", spi_mosi, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_address", ram_address, 32'h8000);
    chk("rst_busy", busy, 0);
    chk("rst_write_complete", write_complete, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);

    // aligned single page with erase, WIP clear after 3 busy status bytes
    wip_polls = 3; mark();
    pulse_start(24'h020000, 9'd1);
    chk("t1_busy", busy, 1);
    wait_end("t1");
    chk("t1_frames", nfr(), 7);
    chk("t1_wake", fb(0, 0), 8'hAB);
    chk("t1_wake_len", flen(0), 1);
    chk("t1_wren_e", fb(1, 0), 8'h06);
    chk("t1_erase_hdr", hdr(2), 32'h20020000);
    chk("t1_erase_len", flen(2), 4);
    chk("t1_poll_e_op", fb(3, 0), 8'h05);
    chk("t1_poll_e_len", flen(3), 5);
    chk("t1_wren_p", fb(4, 0), 8'h06);
    chk("t1_prog_hdr", hdr(5), 32'h02020000);
    chk("t1_prog_len", flen(5), 260);
    chk("t1_prog_data_mis", data_mis(5, 16'h8000), 0);
    chk("t1_poll_p_op", fb(6, 0), 8'h05);
    chk("t1_poll_p_len", flen(6), 5);
    chk("t1_wc_count", wc_n - w0, 1);
    chk("t1_error", error, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_ram_reads", ram_log.size() - r0, 256);
    chk("t1_ram_first", first_ram(), 32'h8000);
    chk("t1_ram_address", ram_address, 32'h8100);

    // unaligned start page, second page crosses into a new sector
    wip_polls = 1; mark();
    pulse_start(24'h020F00, 9'd2);
    wait_end("t2");
    chk("t2_frames", nfr(), 10);
    chk("t2_prog0_hdr", hdr(2), 32'h02020F00);
    chk("t2_prog0_len", flen(2), 260);
    chk("t2_poll_len", flen(3), 3);
    chk("t2_wren_e", fb(4, 0), 8'h06);
    chk("t2_erase_hdr", hdr(5), 32'h20021000);
    chk("t2_prog1_hdr", hdr(8), 32'h02021000);
    chk("t2_prog1_data_mis", data_mis(8, 16'h8100), 0);
    chk("t2_ram_address", ram_address, 32'h8200);
    chk("t2_wc_count", wc_n - w0, 1);

    // zero pages: immediate completion, no bus activity
    mark();
    pulse_start(24'h123400, 9'd0);
    chk("t3_wc_next_cycle", write_complete, 1);
    chk("t3_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("t3_frames", nfr(), 0);
    chk("t3_ram_reads", ram_log.size() - r0, 0);
    chk("t3_wc_count", wc_n - w0, 1);

    // WIP stuck: poll gives up after POLL_LIMIT status bytes
    wip_forever = 1'b1; mark();
    pulse_start(24'h030000, 9'd1);
    wait_end("t4");
    chk("t4_error", error, 1);
    chk("t4_busy", busy, 0);
    chk("t4_spi_cs", spi_cs, 1);
    chk("t4_wc_count", wc_n - w0, 0);
    chk("t4_frames", nfr(), 4);
    chk("t4_erase_hdr", hdr(2), 32'h20030000);
    chk("t4_poll_len", flen(3), 1 + POLL_LIMIT);
    chk("t4_ram_reads", ram_log.size() - r0, 0);
    wip_forever = 1'b0;
    pulse_start(24'h000000, 9'd0);
    chk("t4_error_cleared", error, 0);
    chk("t4_wc_after_clear", write_complete, 1);
    repeat (4) @(negedge clk);

    // asynchronous reset during the 100th data byte
    wip_polls = 0; mark();
    pulse_start(24'h040000, 9'd1);
    begin
      int n = 0;
      while ((ram_log.size() - r0) < 100 && n < 30000) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reached_byte100", 32'(n < 30000), 1);
    end
    repeat (5) @(negedge clk);
    chk("t5_cs_low_before", spi_cs, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_spi_cs", spi_cs, 1);
    chk("t5_rst_ram_cs", ram_cs, 0);
    chk("t5_rst_spi_clk", spi_clk, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ram_address", ram_address, 32'h8000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mark();
    pulse_start(24'h050000, 9'd1);
    wait_end("t5");
    chk("t5_frames", nfr(), 7);
    chk("t5_wake", fb(0, 0), 8'hAB);
    chk("t5_ram_first", first_ram(), 32'h8000);
    chk("t5_prog_hdr", hdr(5), 32'h02050000);
    chk("t5_prog_data_mis", data_mis(5, 16'h8000), 0);
    chk("t5_ram_address", ram_address, 32'h8100);
    chk("t5_wc_count", wc_n - w0, 1);

    // start while busy is ignored
    mark();
    pulse_start(24'h060000, 9'd1);
    repeat (3) @(negedge clk);
    pulse_start(24'h0A0000, 9'd3);
    chk("t6_busy", busy, 1);
    wait_end("t6");
    chk("t6_frames", nfr(), 7);
    chk("t6_erase_hdr", hdr(2), 32'h20060000);
    chk("t6_prog_hdr", hdr(5), 32'h02060000);
    chk("t6_ram_address", ram_address, 32'h8100);
    chk("t6_wc_count", wc_n - w0, 1);

    chk("cs_gap_min_ok", 32'(min_gap >= 2 * CLK_DIV), 1);
    chk("wc_while_busy", wcbusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_writer.md
SPI_FLASH_WRITER -- requirements
Module: spi_flash_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3: spi_clk half-period in clk cycles (range 1..255).
REQ-002 SHALL have parameter RAM_BASE, default 16'h8000: first RAM address read.
REQ-003 SHALL have parameter POLL_LIMIT, default 65535: maximum status reads per busy-wait.
REQ-004 clk  input  1  system clock; all logic on its rising edge; one clock, no derived clocks used as clocks.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a write job.
REQ-007 flash_addr  input  24  start flash address, sampled on accepted start; bits [7:0] ignored (page-aligned).
REQ-008 page_count  input  9  number of 256-byte pages to write, sampled on accepted start.
REQ-009 ram_address  output  16  RAM read address.
REQ-010 ram_dataout  input  8  RAM read data, valid the cycle after ram_cs high.
REQ-011 ram_cs  output  1  RAM read strobe (RAM is never written).
REQ-012 spi_clk, spi_mosi, spi_cs  output  1 each  SPI master pins (spi_cs active-low).
REQ-013 spi_miso  input  1  SPI data from flash.
REQ-014 busy  output  1  high from accepted start until done/error.
REQ-015 write_complete  output  1  one-cycle pulse on successful job end.
REQ-016 error  output  1  sticky; set on poll timeout, cleared by next accepted start.

Function
REQ-017 SPI SHALL be mode 0, MSB first: mosi changes on spi_clk falling edge (or before first rising), miso sampled on rising; spi_clk idles low.
REQ-018 spi_cs SHALL stay high at least 2*CLK_DIV clk cycles between consecutive commands.
REQ-019 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-020 page_count==0 SHALL produce write_complete the cycle after start, no SPI or RAM activity.
REQ-021 State sequence: IDLE -> WAKE (0xAB) -> per page: [if addr[11:0]==0: WREN (0x06) -> ERASE (0x20+3 addr bytes) -> POLL] -> WREN -> PROG (0x02+3 addr bytes+256 data bytes) -> POLL -> NEXT -> ... -> DONE -> IDLE.
REQ-022 Each command SHALL be framed by its own spi_cs low period; PROG SHALL keep spi_cs low across all 260 bytes.
REQ-023 POLL SHALL send 0x05 then read status bytes under one spi_cs low until status bit0 (WIP)==0, then raise spi_cs.
REQ-024 POLL reading more than POLL_LIMIT status bytes SHALL raise spi_cs, set error, drop busy, go to IDLE, no write_complete.
REQ-025 For each PROG data byte, ram_cs SHALL pulse one cycle and ram_dataout be captured before that byte's first spi_clk edge.
REQ-026 ram_address SHALL start at RAM_BASE and increment by 1 per data byte, wrapping 16'hFFFF->16'h0000.
REQ-027 Flash address SHALL advance by 256 in NEXT, wrapping modulo 2^24.
REQ-028 Pages SHALL be programmed in ascending address order; pages written = page_count exactly.
REQ-029 busy SHALL fall in the same cycle write_complete pulses.

Reset
REQ-030 On rst: spi_cs=1, spi_clk=0, spi_mosi=0, ram_cs=0, ram_address=RAM_BASE, busy=0, write_complete=0, error=0, state=IDLE.
REQ-031 rst asserted mid-job SHALL force REQ-030 values immediately (asynchronously), aborting the command; no partial resumption after release.

Verification
REQ-032 flash_addr=24'h020000, page_count=1, flash model WIP clear after 3 polls -> bus shows AB; 06; 20 02 00 00; 05 polled to WIP=0; 06; 02 02 00 00 + 256 bytes from RAM 0x8000..0x80FF; 05 poll; one write_complete.
REQ-033 flash_addr=24'h020F00, page_count=2 -> page 0x020F00 programmed without erase; erase 0x021000 issued before programming 0x021000; ram_address ends at 0x8200.
REQ-034 page_count=0 -> write_complete next cycle, spi_cs never low, ram_cs never high.
REQ-035 Flash model holds WIP=1 forever, POLL_LIMIT=16 -> exactly 16 status bytes, error=1, busy=0, no write_complete; next start clears error.
REQ-036 rst pulsed during 100th PROG data byte -> spi_cs=1 and ram_cs=0 same cycle; second start after release restarts from AB with ram_address=0x8000.
REQ-037 start re-pulsed while busy with different flash_addr -> ignored; job completes with original address.
